// File: rtl/servis_coklu.sv
// Multi-channel coffee service counter: round-robin grant of brew-complete requests,
// per-mode cup yield into a shared counter, and a fixed-length drain at capacity.
module servis_coklu #(
    parameter int KANAL           = 2,
    parameter int GEN             = 6,
    parameter int KAPASITE        = 25,
    parameter int VERIM_FILTRESIZ = 1,
    parameter int VERIM_T0        = 2,
    parameter int VERIM_T1        = 3,
    parameter int BOSALTMA_SURESI = 4
) (
    input  logic             saat,
    input  logic             reset,
    input  logic [KANAL-1:0] basla,
    input  logic [KANAL-1:0] demlendi,
    input  logic [KANAL-1:0] filtrele,
    input  logic [KANAL-1:0] filtre_tipi,
    output logic [KANAL-1:0] kabul,
    output logic             bitti,
    output logic             bosalt,
    output logic             mesgul,
    output logic [GEN-1:0]   kahve_sayisi,
    output logic [7:0]       toplam_bosaltma
);

    localparam int SW = $clog2(KANAL);
    localparam int TW = (BOSALTMA_SURESI > 1) ? $clog2(BOSALTMA_SURESI) : 1;

    localparam logic [SW:0]    KANAL_W    = (SW+1)'(KANAL);
    localparam logic [SW-1:0]  SON_BASLA  = SW'(KANAL - 1);
    localparam logic [GEN:0]   KAPASITE_W = (GEN+1)'(KAPASITE);
    localparam logic [GEN:0]   EK_FSIZ    = (GEN+1)'(VERIM_FILTRESIZ);
    localparam logic [GEN:0]   EK_T0      = (GEN+1)'(VERIM_T0);
    localparam logic [GEN:0]   EK_T1      = (GEN+1)'(VERIM_T1);
    localparam logic [TW-1:0]  TIMER_YUK  = TW'(BOSALTMA_SURESI - 1);

    typedef enum logic [1:0] {
        BEKLE  = 2'd0,
        SERVIS = 2'd1,
        BOSALT = 2'd2
    } durum_t;

    durum_t           state_reg, state_next;
    logic [SW-1:0]    son_reg, son_next;
    logic [KANAL-1:0] kabul_reg, kabul_next;
    logic             bitti_reg, bitti_next;
    logic             bosalt_reg, bosalt_next;
    logic [GEN-1:0]   kahve_reg, kahve_next;
    logic [7:0]       toplam_reg, toplam_next;
    logic [TW-1:0]    timer_reg, timer_next;

    logic [GEN:0]     ek_kanal [KANAL];
    logic [KANAL-1:0] secim_onehot;
    logic [SW-1:0]    secim;
    logic             gecerli;
    logic [SW:0]      aday;
    logic [GEN:0]     ek_sec;
    logic [GEN:0]     yeni;

    // Yield each channel would add if granted now; decoded in parallel so the
    // arbiter only has to mux the winner's value.
    genvar gi;
    generate
        for (gi = 0; gi < KANAL; gi++) begin : g_kanal
            assign ek_kanal[gi] = !demlendi[gi]   ? '0      :
                                  !filtrele[gi]   ? EK_FSIZ :
                                  filtre_tipi[gi] ? EK_T1   : EK_T0;
            assign secim_onehot[gi] = (secim == SW'(gi));
        end
    endgenerate

    // Round-robin: scan son+1, son+2, ... (mod KANAL) and take the first requester.
    always_comb begin
        secim   = son_reg;
        gecerli = 1'b0;
        aday    = '0;
        for (int k = 1; k <= KANAL; k++) begin
            aday = {1'b0, son_reg} + (SW+1)'(k);
            if (aday >= KANAL_W) begin
                aday = aday - KANAL_W;
            end
            if (!gecerli && basla[aday[SW-1:0]]) begin
                gecerli = 1'b1;
                secim   = aday[SW-1:0];
            end
        end
    end

    // One extra bit so an overshoot past 2^GEN-1 still compares correctly.
    assign ek_sec = ek_kanal[secim];
    assign yeni   = {1'b0, kahve_reg} + ek_sec;

    always_comb begin
        state_next  = state_reg;
        son_next    = son_reg;
        kabul_next  = '0;
        bitti_next  = 1'b0;
        bosalt_next = bosalt_reg;
        kahve_next  = kahve_reg;
        toplam_next = toplam_reg;
        timer_next  = timer_reg;

        case (state_reg)
            BEKLE: begin
                if (gecerli) begin
                    kabul_next = secim_onehot;
                    bitti_next = 1'b1;
                    son_next   = secim;
                    if (yeni < KAPASITE_W) begin
                        kahve_next = yeni[GEN-1:0];
                        state_next = SERVIS;
                    end else begin
                        // Excess above capacity is discarded with the drain.
                        kahve_next  = '0;
                        bosalt_next = 1'b1;
                        timer_next  = TIMER_YUK;
                        state_next  = BOSALT;
                    end
                end
            end
            SERVIS: begin
                state_next = BEKLE;
            end
            BOSALT: begin
                if (timer_reg == '0) begin
                    bosalt_next = 1'b0;
                    toplam_next = toplam_reg + 8'd1;
                    state_next  = BEKLE;
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end
            default: begin
                state_next = BEKLE;
            end
        endcase
    end

    always_ff @(posedge saat) begin
        if (!reset) begin
            state_reg  <= BEKLE;
            son_reg    <= SON_BASLA;
            kabul_reg  <= '0;
            bitti_reg  <= 1'b0;
            bosalt_reg <= 1'b0;
            kahve_reg  <= '0;
            toplam_reg <= '0;
            timer_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            son_reg    <= son_next;
            kabul_reg  <= kabul_next;
            bitti_reg  <= bitti_next;
            bosalt_reg <= bosalt_next;
            kahve_reg  <= kahve_next;
            toplam_reg <= toplam_next;
            timer_reg  <= timer_next;
        end
    end

    assign kabul           = kabul_reg;
    assign bitti           = bitti_reg;
    assign bosalt          = bosalt_reg;
    assign mesgul          = (state_reg != BEKLE);
    assign kahve_sayisi    = kahve_reg;
    assign toplam_bosaltma = toplam_reg;

endmodule

// File: tb/tb_servis_coklu.sv
// Bench for servis_coklu: directed scenarios plus randomized traffic against a
// cycle model built from the grant/yield/drain rules.
module tb_servis_coklu;

    localparam int K   = 2;
    localparam int GEN = 6;
    localparam int KAP = 25;
    localparam int BOS = 4;
    localparam int W   = K + 3 + GEN + 8;

    logic           saat = 1'b0;
    logic           reset = 1'b0;
    logic [K-1:0]   basla = '0;
    logic [K-1:0]   demlendi = '0;
    logic [K-1:0]   filtrele = '0;
    logic [K-1:0]   filtre_tipi = '0;
    logic [K-1:0]   kabul;
    logic           bitti;
    logic           bosalt;
    logic           mesgul;
    logic [GEN-1:0] kahve_sayisi;
    logic [7:0]     toplam_bosaltma;

    int checks = 0;
    int errors = 0;

    // Model: cup count, drain total, last granted channel, remaining visible
    // drain cycles, and whether the current cycle is the single service cycle.
    int           m_count  = 0;
    int           m_drains = 0;
    int           m_last   = K - 1;
    int           m_drain  = 0;
    bit           m_serv   = 0;
    logic [K-1:0] m_kabul  = '0;
    bit           m_bitti  = 0;

    servis_coklu dut (
        .saat(saat), .reset(reset), .basla(basla), .demlendi(demlendi),
        .filtrele(filtrele), .filtre_tipi(filtre_tipi), .kabul(kabul),
        .bitti(bitti), .bosalt(bosalt), .mesgul(mesgul),
        .kahve_sayisi(kahve_sayisi), .toplam_bosaltma(toplam_bosaltma)
    );

    always #5 saat = ~saat;

    logic [W-1:0] obs_vec;
    assign obs_vec = {kabul, bitti, bosalt, mesgul, kahve_sayisi, toplam_bosaltma};

    function automatic logic [W-1:0] beklenen();
        logic [W-1:0] v;
        logic [31:0]  c;
        logic [31:0]  d;
        c = m_count;
        d = m_drains;
        v = {m_kabul, m_bitti, (m_drain > 0), (m_serv || m_drain > 0), c[GEN-1:0], d[7:0]};
        return v;
    endfunction

    function automatic int yield_of(input int ch);
        if (!demlendi[ch]) return 0;
        if (!filtrele[ch]) return 1;
        return filtre_tipi[ch] ? 3 : 2;
    endfunction

    // Advance the model by one edge using the inputs the DUT is about to sample.
    task automatic model_step();
        int pick;
        int yeni;
        m_kabul = '0;
        m_bitti = 0;
        if (!reset) begin
            m_count = 0; m_drains = 0; m_last = K - 1; m_drain = 0; m_serv = 0;
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) m_drains = (m_drains + 1) % 256;
        end else if (m_serv) begin
            m_serv = 0;
        end else if (basla != '0) begin
            pick = -1;
            for (int k = 1; k <= K; k++) begin
                if (pick < 0 && basla[(m_last + k) % K]) pick = (m_last + k) % K;
            end
            yeni = m_count + yield_of(pick);
            m_kabul[pick] = 1'b1;
            m_bitti = 1;
            m_last = pick;
            if (yeni >= KAP) begin
                m_count = 0;
                m_drain = BOS;
            end else begin
                m_count = yeni;
                m_serv = 1;
            end
        end
    endtask

    // One clock: model, edge, then the requester drops basla in its kabul cycle.
    task automatic cycle();
        model_step();
        @(posedge saat);
        #1;
        basla = basla & ~m_kabul;
    endtask

    task automatic request(input int ch, input bit d, input bit f, input bit t);
        basla[ch] = 1'b1; demlendi[ch] = d; filtrele[ch] = f; filtre_tipi[ch] = t;
    endtask

    task automatic do_reset();
        basla = '0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic fill(input int ch, input int n, input bit d, input bit f, input bit t);
        for (int i = 0; i < n; i++) begin
            request(ch, d, f, t);
            for (int c = 0; c < 2; c++) begin
                cycle();
                checks++;
                if (obs_vec !== beklenen()) begin
                    errors++;
                    $display("FAIL fill ch%0d n%0d got %h exp %h", ch, i, obs_vec, beklenen());
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (obs_vec !== beklenen()) begin
                errors++;
                $display("FAIL reset_idle cyc%0d got %h exp %h", i, obs_vec, beklenen());
            end
        end
        checks++;
        if (obs_vec !== '0) begin
            errors++;
            $display("FAIL reset_zero got %h exp 0", obs_vec);
        end
    endtask

    task automatic test_single();
        request(0, 1, 1, 1);
        cycle();
        checks++;
        if (kabul !== 2'b01 || bitti !== 1'b1 || kahve_sayisi !== 6'd3 || mesgul !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got kabul=%b bitti=%b kahve=%0d mesgul=%b exp 01 1 3 1",
                     kabul, bitti, kahve_sayisi, mesgul);
        end
        cycle();
        checks++;
        if (kabul !== 2'b00 || mesgul !== 1'b0) begin
            errors++;
            $display("FAIL single_after got kabul=%b mesgul=%b exp 00 0", kabul, mesgul);
        end
    endtask

    task automatic test_round_robin();
        logic [K-1:0] sira [4];
        sira[0] = 2'b01; sira[1] = 2'b10; sira[2] = 2'b01; sira[3] = 2'b10;
        do_reset();
        request(0, 0, 0, 0);
        request(1, 0, 0, 0);
        for (int n = 0; n < 8; n++) begin
            cycle();
            checks++;
            if (n % 2 == 0 && kabul !== sira[n/2]) begin
                errors++;
                $display("FAIL rr_grant%0d got %b exp %b", n/2, kabul, sira[n/2]);
            end else if (n % 2 == 1 && kabul !== 2'b00) begin
                errors++;
                $display("FAIL rr_gap%0d got %b exp 00", n/2, kabul);
            end
            basla = ~m_kabul;
        end
        basla = '0;
        cycle();
    endtask

    task automatic test_drain_exact();
        int hi;
        do_reset();
        fill(0, 8, 1, 1, 1);
        request(1, 1, 0, 0);
        cycle();
        checks++;
        if (kabul !== 2'b10 || bitti !== 1'b1 || kahve_sayisi !== 6'd0 || bosalt !== 1'b1) begin
            errors++;
            $display("FAIL exact_grant got kabul=%b bitti=%b kahve=%0d bosalt=%b exp 10 1 0 1",
                     kabul, bitti, kahve_sayisi, bosalt);
        end
        request(0, 0, 0, 0);
        hi = 1;
        for (int i = 0; i < 20 && bosalt === 1'b1; i++) begin
            cycle();
            checks++;
            if (obs_vec !== beklenen()) begin
                errors++;
                $display("FAIL exact_drain cyc%0d got %h exp %h", i, obs_vec, beklenen());
            end
            if (bosalt === 1'b1) hi++;
        end
        checks++;
        if (hi !== BOS || toplam_bosaltma !== 8'd1) begin
            errors++;
            $display("FAIL exact_len got %0d cycles total=%0d exp %0d cycles total=1",
                     hi, toplam_bosaltma, BOS);
        end
        cycle();
        checks++;
        if (kabul !== 2'b01) begin
            errors++;
            $display("FAIL exact_held got %b exp 01", kabul);
        end
        cycle();
    endtask

    task automatic test_overshoot();
        do_reset();
        fill(0, 7, 1, 1, 1);
        fill(0, 1, 1, 1, 0);
        request(0, 1, 1, 1);
        cycle();
        checks++;
        if (kahve_sayisi !== 6'd0 || bosalt !== 1'b1) begin
            errors++;
            $display("FAIL overshoot got kahve=%0d bosalt=%b exp 0 1", kahve_sayisi, bosalt);
        end
        for (int i = 0; i < 20 && mesgul === 1'b1; i++) begin
            cycle();
            checks++;
            if (obs_vec !== beklenen()) begin
                errors++;
                $display("FAIL overshoot_drain cyc%0d got %h exp %h", i, obs_vec, beklenen());
            end
        end
        checks++;
        if (mesgul !== 1'b0) begin
            errors++;
            $display("FAIL overshoot_timeout got mesgul=%b exp 0", mesgul);
        end
    endtask

    task automatic test_reset_mid_drain();
        fill(0, 8, 1, 1, 1);
        request(1, 1, 1, 1);
        cycle();
        cycle();
        checks++;
        if (obs_vec !== beklenen()) begin
            errors++;
            $display("FAIL mid_before got %h exp %h", obs_vec, beklenen());
        end
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        checks++;
        if (bosalt !== 1'b0 || mesgul !== 1'b0 || toplam_bosaltma !== 8'd0 || kahve_sayisi !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset got bosalt=%b mesgul=%b total=%0d kahve=%0d exp 0 0 0 0",
                     bosalt, mesgul, toplam_bosaltma, kahve_sayisi);
        end
        request(0, 0, 0, 0);
        request(1, 0, 0, 0);
        cycle();
        checks++;
        if (kabul !== 2'b01) begin
            errors++;
            $display("FAIL mid_next got %b exp 01", kabul);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (obs_vec !== beklenen()) begin
                errors++;
                $display("FAIL mid_after cyc%0d got %h exp %h", i, obs_vec, beklenen());
            end
        end
    endtask

    task automatic test_zero_yield();
        do_reset();
        fill(0, 2, 1, 1, 1);
        fill(1, 1, 1, 0, 0);
        request(0, 0, 1, 1);
        cycle();
        checks++;
        if (bitti !== 1'b1 || kahve_sayisi !== 6'd7) begin
            errors++;
            $display("FAIL zero_yield got bitti=%b kahve=%0d exp 1 7", bitti, kahve_sayisi);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            for (int c = 0; c < K; c++) begin
                if (!basla[c] && $urandom_range(0, 2) == 0) begin
                    request(c, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                            $urandom_range(0, 1) == 1);
                end
            end
            cycle();
            checks++;
            if (obs_vec !== beklenen()) begin
                errors++;
                $display("FAIL random cyc%0d got %h exp %h", n, obs_vec, beklenen());
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drain_exact();
        test_overshoot();
        test_reset_mid_drain();
        test_zero_yield();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servis_coklu.md
Name: servis_coklu

Overview:
- Multi-channel successor to the single-requester coffee service counter.
- Arbitrates brew-completion requests from KANAL brewer channels round-robin and adds a per-mode yield to a shared cup counter.
- When the counter reaches capacity, runs a multi-cycle drain sequence, during which it grants no requests.
- Sits between the brewer channels and the dispenser/drain controller.

Parameters:
- KANAL, 2: number of requesting channels (>=2).
- GEN, 6: width of kahve_sayisi; KAPASITE must be <= 2^GEN-1.
- KAPASITE, 25: counter threshold that triggers a drain.
- VERIM_FILTRESIZ, 1: cups added when the unfiltered brew mode is selected.
- VERIM_T0, 2: cups added for filtered brew, filtre_tipi=0.
- VERIM_T1, 3: cups added for filtered brew, filtre_tipi=1.
- BOSALTMA_SURESI, 4: drain length in cycles (>=1).

Ports:
- saat  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- basla  in  KANAL  per-channel request; held high until kabul for that channel.
- demlendi  in  KANAL  per-channel brew-complete qualifier.
- filtrele  in  KANAL  per-channel filter enable.
- filtre_tipi  in  KANAL  per-channel filter type.
- kabul  out  KANAL  one-hot grant; 1-cycle pulse.
- bitti  out  1  service-done pulse, coincident with kabul.
- bosalt  out  1  high for the entire drain sequence.
- mesgul  out  1  high when state != BEKLE.
- kahve_sayisi  out  GEN  current cup count.
- toplam_bosaltma  out  8  number of completed drains; wraps 255->0.

Behaviour:
- Reset (reset==0 at edge):
  - state=BEKLE.
  - kabul=0, bitti=0, bosalt=0, kahve_sayisi=0, toplam_bosaltma=0.
  - Drain timer=0; round-robin pointer son=KANAL-1, so channel 0 has first priority.
  - Reset dominates every other condition, including mid-drain: the drain is abandoned and toplam_bosaltma is cleared.
- States: BEKLE, SERVIS, BOSALT.
- BEKLE, no basla bit set: all outputs hold, kabul=bitti=0.
- BEKLE, any basla bit set:
  - Pick channel i = first set bit scanning son+1, son+2, ... mod KANAL.
  - Compute ek for channel i:
    - demlendi[i]=0 -> 0.
    - demlendi[i]=1, filtrele[i]=0 -> VERIM_FILTRESIZ.
    - demlendi[i]=1, filtrele[i]=1 -> VERIM_T0 or VERIM_T1, selected by filtre_tipi[i].
  - yeni = kahve_sayisi + ek, computed GEN+1 bits wide; no truncation before the compare.
  - Next edge, always: kabul<=onehot(i), bitti<=1, son<=i.
  - Next edge, yeni < KAPASITE: kahve_sayisi<=yeni, state->SERVIS.
  - Next edge, yeni >= KAPASITE: kahve_sayisi<=0, bosalt<=1, timer<=BOSALTMA_SURESI-1, state->BOSALT.
- SERVIS: exactly one cycle.
  - kabul and bitti are high in this cycle; no arbitration.
  - Next edge: kabul<=0, bitti<=0, state->BEKLE.
  - Peak throughput is therefore one grant per 2 cycles.
- BOSALT:
  - bosalt stays high for exactly BOSALTMA_SURESI cycles.
  - kabul/bitti are high only in the first BOSALT cycle.
  - No grants; pending basla bits wait, since requesters hold them.
  - timer decrements each cycle.
  - At the edge where timer==0: bosalt<=0, toplam_bosaltma<=toplam_bosaltma+1, state->BEKLE.
- Latency:
  - Grant is registered one edge after basla is sampled in BEKLE.
  - The requester drops basla in its kabul cycle; the block ignores basla outside BEKLE, so a held request cannot be double-granted.
- basla with demlendi=0: granted with ek=0; kahve_sayisi is unchanged; bitti still pulses.
- Simultaneous requests: exactly one grant per arbitration. A channel continuously requesting is granted at least once every KANAL arbitrations (no starvation).
- Exact hit (yeni==KAPASITE) triggers a drain, the same as overshoot; the excess above KAPASITE is discarded.

Test Plan:
- Reset release, idle:
  - Stimulus: no basla for 10 cycles.
  - Required: all outputs 0, mesgul=0.
- Single request:
  - Stimulus: ch0 basla with demlendi=1, filtrele=1, tipi=1, from count 0.
  - Required: next cycle kabul=01, bitti=1, kahve_sayisi=3, mesgul=1; following cycle kabul=0, mesgul=0.
- Round-robin:
  - Stimulus: ch0 and ch1 basla held continuously, each dropped after its kabul.
  - Required: grant order ch0, ch1, ch0, ch1; grants two cycles apart.
- Drain on exact hit:
  - Stimulus: count 24, ch1 request with demlendi=1, filtrele=0.
  - Required: kabul=10, bitti=1; kahve_sayisi=0; bosalt high for exactly 4 cycles; toplam_bosaltma 0->1 as bosalt falls.
  - Required: a ch0 request held during the drain is granted 1 cycle after BEKLE is re-entered.
- Drain on overshoot:
  - Stimulus: count 23, request with filtrele=1, tipi=1 (yeni=26).
  - Required: drain starts, kahve_sayisi=0 (no residue of 1).
- Reset mid-drain:
  - Stimulus: reset=0 for one edge during the 2nd bosalt cycle.
  - Required: next cycle bosalt=0, state BEKLE, toplam_bosaltma=0; the next grant goes to ch0.
- Zero-yield request:
  - Stimulus: demlendi=0 request at count 7.
  - Required: bitti pulse, kahve_sayisi stays 7.
